// File: rtl/hdlc_ctrl_pkg.sv
// HDLC controller register map, Tx_SC bit positions and
// the transmit scheduler state encoding.
package hdlc_ctrl_pkg;

    localparam logic [2:0] ADDR_TX_SC   = 3'd0;
    localparam logic [2:0] ADDR_TX_BUFF = 3'd1;

    localparam int SC_DONE    = 0;
    localparam int SC_ENABLE  = 1;
    localparam int SC_ABORT   = 2;
    localparam int SC_ABORTED = 3;
    localparam int SC_FULL    = 4;

    localparam logic [7:0] SC_CMD_START = 8'h02;
    localparam logic [7:0] SC_CMD_ABORT = 8'h04;

    localparam int HDLC_MAX_LEN = 126;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_ERR,
        S_POLL_RD,
        S_POLL_CHK,
        S_LOAD,
        S_START,
        S_WAIT_RD,
        S_WAIT_CHK,
        S_ABORT,
        S_ABORT_RD,
        S_ABORT_CHK
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first request strictly after i_ptr,
// wrapping around; purely combinational.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!o_any && i_req[j] && (j > int'(i_ptr))) begin
                o_any    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IDX_W'(j);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!o_any && i_req[j] && (j <= int'(i_ptr))) begin
                o_any    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/hdlc_tx_scheduler.sv
// Shares one HDLC transmitter among N_REQ frame sources:
// arbitrate, poll Tx_SC, load Tx_Buff, start, await done/abort.
module hdlc_tx_scheduler
    import hdlc_ctrl_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int LEN_W       = 7,
    parameter int MAX_LEN     = HDLC_MAX_LEN,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [N_REQ-1:0]   Req_Valid,
    input  logic [N_REQ*LEN_W-1:0] Req_Len,
    input  logic [N_REQ*8-1:0] Req_Data,
    output logic [N_REQ-1:0]   Req_Grant,
    output logic               Req_Pop,
    output logic [N_REQ-1:0]   Req_Done,
    output logic [N_REQ-1:0]   Req_Err,
    input  logic               Abort_In,
    output logic [2:0]         Hdlc_Addr,
    output logic               Hdlc_WrEn,
    output logic               Hdlc_RdEn,
    output logic [7:0]         Hdlc_WrData,
    input  logic [7:0]         Hdlc_RdData,
    output logic               Busy
);

    localparam int IDX_W = $clog2(N_REQ);

    sched_state_t     r_state;
    sched_state_t     w_next;
    logic [IDX_W-1:0] r_rr;
    logic [IDX_W-1:0] r_idx;
    logic [N_REQ-1:0] r_grant;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [15:0]      r_tmo;

    logic [N_REQ-1:0] w_arb_gnt;
    logic [IDX_W-1:0] w_arb_idx;
    logic             w_arb_any;
    logic [LEN_W-1:0] w_len;
    logic [7:0]       w_data;
    logic             w_len_ok;
    logic             w_tmo_hit;
    logic             w_sc_done;
    logic             w_sc_full;
    logic             w_sc_abtd;
    logic             w_in_wait;
    logic             w_wr;
    logic             w_rd;
    logic [2:0]       w_addr;
    logic [7:0]       w_wdata;
    logic             w_pop;
    logic             w_done;
    logic             w_err;
    logic             w_unused_rd;

    rr_arbiter #(
        .N_REQ(N_REQ),
        .IDX_W(IDX_W)
    ) u_arb (
        .i_req(Req_Valid),
        .i_ptr(r_rr),
        .o_gnt(w_arb_gnt),
        .o_idx(w_arb_idx),
        .o_any(w_arb_any)
    );

    always_comb begin
        w_len  = '0;
        w_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_arb_idx == IDX_W'(i))
                w_len = Req_Len[i*LEN_W +: LEN_W];
            if (r_idx == IDX_W'(i))
                w_data = Req_Data[i*8 +: 8];
        end
    end

    assign w_len_ok  = (w_len != '0) &&
                       (w_len <= LEN_W'(MAX_LEN));
    assign w_tmo_hit = (r_tmo >= 16'(TIMEOUT_CYC));
    assign w_sc_done = Hdlc_RdData[SC_DONE];
    assign w_sc_full = Hdlc_RdData[SC_FULL];
    assign w_sc_abtd = Hdlc_RdData[SC_ABORTED];
    assign w_in_wait = (r_state == S_WAIT_RD) ||
                       (r_state == S_WAIT_CHK);
    assign w_unused_rd = ^{Hdlc_RdData[7:5],
                           Hdlc_RdData[2:1]};

    always_comb begin
        w_next  = r_state;
        w_wr    = 1'b0;
        w_rd    = 1'b0;
        w_addr  = ADDR_TX_SC;
        w_wdata = 8'h00;
        w_pop   = 1'b0;
        w_done  = 1'b0;
        w_err   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_arb_any)
                    w_next = w_len_ok ? S_POLL_RD : S_LEN_ERR;
            end
            S_LEN_ERR: begin
                w_err  = 1'b1;
                w_next = S_IDLE;
            end
            S_POLL_RD: begin
                w_rd   = 1'b1;
                w_next = S_POLL_CHK;
            end
            S_POLL_CHK: begin
                w_next = (w_sc_done && !w_sc_full) ?
                         S_LOAD : S_POLL_RD;
            end
            S_LOAD: begin
                if (Abort_In) begin
                    w_next = S_ABORT;
                end else begin
                    w_wr    = 1'b1;
                    w_addr  = ADDR_TX_BUFF;
                    w_wdata = w_data;
                    w_pop   = 1'b1;
                    if (r_cnt == r_len - 1'b1)
                        w_next = S_START;
                end
            end
            S_START: begin
                if (Abort_In) begin
                    w_next = S_ABORT;
                end else begin
                    w_wr    = 1'b1;
                    w_wdata = SC_CMD_START;
                    w_next  = S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                if (Abort_In || w_tmo_hit) begin
                    w_next = S_ABORT;
                end else begin
                    w_rd   = 1'b1;
                    w_next = S_WAIT_CHK;
                end
            end
            S_WAIT_CHK: begin
                // a completed frame beats a same-cycle abort
                if (w_sc_done) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end else if (Abort_In || w_tmo_hit) begin
                    w_next = S_ABORT;
                end else begin
                    w_next = S_WAIT_RD;
                end
            end
            S_ABORT: begin
                w_wr    = 1'b1;
                w_wdata = SC_CMD_ABORT;
                w_next  = S_ABORT_RD;
            end
            S_ABORT_RD: begin
                w_rd   = 1'b1;
                w_next = S_ABORT_CHK;
            end
            S_ABORT_CHK: begin
                if (w_sc_abtd || w_sc_done) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_next = S_ABORT_RD;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
            r_rr    <= IDX_W'(N_REQ - 1);
            r_idx   <= '0;
            r_grant <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_arb_any) begin
                r_grant <= w_arb_gnt;
                r_idx   <= w_arb_idx;
                r_rr    <= w_arb_idx;
                r_len   <= w_len;
            end
            if (w_done || w_err)
                r_grant <= '0;
            if (r_state == S_POLL_CHK)
                r_cnt <= '0;
            else if (w_pop)
                r_cnt <= r_cnt + 1'b1;
            if (r_state == S_START)
                r_tmo <= '0;
            else if (w_in_wait && (r_tmo != 16'hFFFF))
                r_tmo <= r_tmo + 16'd1;
        end
    end

    // gate strobes so a reset cycle never touches the bus
    assign Req_Grant   = r_grant;
    assign Req_Pop     = w_pop & ~Rst;
    assign Req_Done    = (w_done && !Rst) ? r_grant : '0;
    assign Req_Err     = (w_err && !Rst) ? r_grant : '0;
    assign Hdlc_WrEn   = w_wr & ~Rst;
    assign Hdlc_RdEn   = w_rd & ~Rst;
    assign Hdlc_Addr   = Rst ? 3'd0 : w_addr;
    assign Hdlc_WrData = Rst ? 8'h00 : w_wdata;
    assign Busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_hdlc_tx_scheduler.sv
// Directed bench for hdlc_tx_scheduler with a small
// behavioural Tx_SC/Tx_Buff register model.
module tb_hdlc_tx_scheduler;

    localparam int N   = 4;
    localparam int LW  = 7;
    localparam int TMO = 300;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic [N-1:0]  Req_Valid = '0;
    logic [N*LW-1:0] Req_Len = '0;
    logic [N*8-1:0] Req_Data;
    logic          Abort_In = 1'b0;
    logic [7:0]    Hdlc_RdData = 8'h00;
    logic [N-1:0]  Req_Grant;
    logic          Req_Pop;
    logic [N-1:0]  Req_Done;
    logic [N-1:0]  Req_Err;
    logic [2:0]    Hdlc_Addr;
    logic          Hdlc_WrEn;
    logic          Hdlc_RdEn;
    logic [7:0]    Hdlc_WrData;
    logic          Busy;

    hdlc_tx_scheduler #(
        .N_REQ(N), .LEN_W(LW), .MAX_LEN(126), .TIMEOUT_CYC(TMO)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .Req_Valid(Req_Valid), .Req_Len(Req_Len),
        .Req_Data(Req_Data), .Req_Grant(Req_Grant),
        .Req_Pop(Req_Pop), .Req_Done(Req_Done),
        .Req_Err(Req_Err), .Abort_In(Abort_In),
        .Hdlc_Addr(Hdlc_Addr), .Hdlc_WrEn(Hdlc_WrEn),
        .Hdlc_RdEn(Hdlc_RdEn), .Hdlc_WrData(Hdlc_WrData),
        .Hdlc_RdData(Hdlc_RdData), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // knobs written by the stimulus
    int m_dly = 5;
    int m_alat = 3;
    int m_full_knob = 0;
    logic [7:0] src_mem [4][8];

    // state owned by the model
    int m_cyc = 0, m_cnt = 0, m_acnt = 0;
    logic m_busy = 1'b0, m_abt = 1'b0;
    int m_full_used = 0, m_nbuf = 0, m_nstart = 0;
    int m_nabort = 0, m_pops = 0, m_both = 0;
    int m_early = 0, m_ng = 0, m_abt_seen = 0;
    int m_multi = 0, m_t_start = 0, m_t_abort = 0;
    int m_done [4] = '{0, 0, 0, 0};
    int m_err  [4] = '{0, 0, 0, 0};
    int src_ptr [4] = '{0, 0, 0, 0};
    logic [7:0] m_buf [64];
    logic [3:0] m_glog [32];
    logic [3:0] m_prev_g = '0;

    int n_cmp = 0;
    int n_bad = 0;

    int b_nbuf, b_start, b_abort, b_pops, b_ng;
    int b_end, b_full, b_abts;
    int b_done [4];
    int b_err [4];

    always_comb begin
        for (int i = 0; i < N; i++)
            Req_Data[i*8 +: 8] = src_mem[i][src_ptr[i][2:0]];
    end

    always @(posedge Clk) begin
        m_cyc    <= m_cyc + 1;
        m_prev_g <= Req_Grant;
        if (Req_Grant != 0 && m_prev_g == 0) begin
            m_glog[m_ng & 31] <= Req_Grant;
            m_ng <= m_ng + 1;
            for (int i = 0; i < N; i++)
                if (Req_Grant[i]) src_ptr[i] <= 0;
        end
        if (!$onehot0(Req_Grant)) m_multi <= m_multi + 1;
        if (Req_Pop) begin
            m_pops <= m_pops + 1;
            for (int i = 0; i < N; i++)
                if (Req_Grant[i]) src_ptr[i] <= src_ptr[i] + 1;
        end
        if (Hdlc_WrEn && Hdlc_RdEn) m_both <= m_both + 1;
        for (int i = 0; i < N; i++) begin
            if (Req_Done[i]) m_done[i] <= m_done[i] + 1;
            if (Req_Err[i])  m_err[i]  <= m_err[i] + 1;
        end
        if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_busy <= 1'b0;
        end
        if (m_acnt > 0) begin
            m_acnt <= m_acnt - 1;
            if (m_acnt == 1) begin
                m_busy <= 1'b0;
                m_abt  <= 1'b1;
            end
        end
        if (Hdlc_WrEn && Hdlc_Addr == 3'd1) begin
            m_buf[m_nbuf & 63] <= Hdlc_WrData;
            m_nbuf <= m_nbuf + 1;
            if (m_full_used < m_full_knob) m_early <= m_early + 1;
        end
        if (Hdlc_WrEn && Hdlc_Addr == 3'd0 && Hdlc_WrData == 8'h02) begin
            m_nstart  <= m_nstart + 1;
            m_t_start <= m_cyc;
            m_busy    <= 1'b1;
            m_cnt     <= (m_dly > 0) ? m_dly : 0;
        end
        if (Hdlc_WrEn && Hdlc_Addr == 3'd0 && Hdlc_WrData == 8'h04) begin
            m_nabort  <= m_nabort + 1;
            m_t_abort <= m_cyc;
            m_busy    <= 1'b1;
            m_abt     <= 1'b0;
            m_cnt     <= 0;
            m_acnt    <= m_alat;
        end
        if (Hdlc_RdEn) begin
            Hdlc_RdData <= {3'b000, (m_full_used < m_full_knob),
                            m_abt, 2'b00, !m_busy};
            if (m_full_used < m_full_knob)
                m_full_used <= m_full_used + 1;
            if (m_abt) begin
                m_abt      <= 1'b0;
                m_abt_seen <= m_abt_seen + 1;
            end
        end
    end

    function automatic int ends();
        int s = 0;
        for (int i = 0; i < N; i++) s += m_done[i] + m_err[i];
        return s;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_nbuf  = m_nbuf;
        b_start = m_nstart;
        b_abort = m_nabort;
        b_pops  = m_pops;
        b_ng    = m_ng;
        b_end   = ends();
        b_full  = m_full_used;
        b_abts  = m_abt_seen;
        for (int i = 0; i < N; i++) begin
            b_done[i] = m_done[i];
            b_err[i]  = m_err[i];
        end
    endtask

    task automatic wait_ng(input int target);
        int t = 0;
        while (m_ng < target && t < 2000) begin
            @(negedge Clk);
            t++;
        end
        chk("grant_wait", int'(m_ng >= target), 1);
    endtask

    task automatic wait_end(input int target);
        int t = 0;
        while (ends() < target && t < 3000) begin
            @(negedge Clk);
            t++;
        end
        chk("end_wait", int'(ends() >= target), 1);
        repeat (3) @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_grant"}, int'(Req_Grant), 0);
        chk({tag, "_busy"}, int'(Busy), 0);
        chk({tag, "_wren"}, int'(Hdlc_WrEn), 0);
        chk({tag, "_rden"}, int'(Hdlc_RdEn), 0);
        chk({tag, "_pop"}, int'(Req_Pop), 0);
        chk({tag, "_done"}, int'(Req_Done), 0);
        chk({tag, "_err"}, int'(Req_Err), 0);
    endtask

    initial begin
        int t;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 8; k++)
                src_mem[i][k] = 8'(16 * i + k + 1);
        src_mem[0][0] = 8'hA5;
        src_mem[0][1] = 8'h3C;
        src_mem[0][2] = 8'h7E;
        src_mem[3][0] = 8'h11;
        src_mem[3][1] = 8'h22;

        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        chk_quiet("reset");

        // single frame from source 0
        Req_Len = {7'd1, 7'd1, 7'd1, 7'd3};
        snap();
        Req_Valid = 4'b0001;
        wait_ng(b_ng + 1);
        Req_Valid = 4'b0000;
        wait_end(b_end + 1);
        chk("s1_grant", int'(m_glog[b_ng]), 1);
        chk("s1_nbuf", m_nbuf - b_nbuf, 3);
        chk("s1_b0", int'(m_buf[b_nbuf]), 'hA5);
        chk("s1_b1", int'(m_buf[b_nbuf + 1]), 'h3C);
        chk("s1_b2", int'(m_buf[b_nbuf + 2]), 'h7E);
        chk("s1_start", m_nstart - b_start, 1);
        chk("s1_abort", m_nabort - b_abort, 0);
        chk("s1_pops", m_pops - b_pops, 3);
        chk("s1_done0", m_done[0] - b_done[0], 1);
        chk("s1_err0", m_err[0] - b_err[0], 0);

        // round robin across all four, then wrap to source 2
        do_reset();
        Req_Len = {7'd1, 7'd1, 7'd1, 7'd1};
        snap();
        Req_Valid = 4'b1111;
        wait_ng(b_ng + 5);
        Req_Valid = 4'b0100;
        wait_ng(b_ng + 6);
        Req_Valid = 4'b0000;
        wait_end(b_end + 6);
        chk("s2_g0", int'(m_glog[b_ng + 0]), 1);
        chk("s2_g1", int'(m_glog[b_ng + 1]), 2);
        chk("s2_g2", int'(m_glog[b_ng + 2]), 4);
        chk("s2_g3", int'(m_glog[b_ng + 3]), 8);
        chk("s2_g4", int'(m_glog[b_ng + 4]), 1);
        chk("s2_g5", int'(m_glog[b_ng + 5]), 4);
        chk("s2_done0", m_done[0] - b_done[0], 2);
        chk("s2_done2", m_done[2] - b_done[2], 2);
        chk("s2_nbuf", m_nbuf - b_nbuf, 6);

        // length 0 and 127 are rejected without bus traffic
        Req_Len = {7'd1, 7'd1, 7'd127, 7'd0};
        snap();
        Req_Valid = 4'b0111;
        wait_ng(b_ng + 3);
        Req_Valid = 4'b0000;
        wait_end(b_end + 3);
        chk("s3_g0", int'(m_glog[b_ng + 0]), 1);
        chk("s3_g1", int'(m_glog[b_ng + 1]), 2);
        chk("s3_g2", int'(m_glog[b_ng + 2]), 4);
        chk("s3_err0", m_err[0] - b_err[0], 1);
        chk("s3_err1", m_err[1] - b_err[1], 1);
        chk("s3_done2", m_done[2] - b_done[2], 1);
        chk("s3_nbuf", m_nbuf - b_nbuf, 1);
        chk("s3_start", m_nstart - b_start, 1);
        chk("s3_pops", m_pops - b_pops, 1);

        // Tx_Full reported for ten polls
        Req_Len = {7'd2, 7'd1, 7'd1, 7'd1};
        m_full_knob = m_full_used + 10;
        snap();
        Req_Valid = 4'b1000;
        wait_ng(b_ng + 1);
        Req_Valid = 4'b0000;
        wait_end(b_end + 1);
        chk("s4_full_polls", m_full_used - b_full, 10);
        chk("s4_early", m_early, 0);
        chk("s4_nbuf", m_nbuf - b_nbuf, 2);
        chk("s4_b0", int'(m_buf[b_nbuf]), 'h11);
        chk("s4_b1", int'(m_buf[b_nbuf + 1]), 'h22);
        chk("s4_done3", m_done[3] - b_done[3], 1);

        // abort pulse during LOAD after two bytes
        Req_Len = {7'd2, 7'd1, 7'd1, 7'd5};
        snap();
        Req_Valid = 4'b0001;
        wait_ng(b_ng + 1);
        Req_Valid = 4'b0000;
        t = 0;
        while (m_nbuf < b_nbuf + 2 && t < 500) begin
            @(negedge Clk);
            t++;
        end
        Abort_In = 1'b1;
        @(negedge Clk);
        Abort_In = 1'b0;
        wait_end(b_end + 1);
        chk("s5_nbuf", m_nbuf - b_nbuf, 2);
        chk("s5_pops", m_pops - b_pops, 2);
        chk("s5_abort", m_nabort - b_abort, 1);
        chk("s5_start", m_nstart - b_start, 0);
        chk("s5_abt_seen", m_abt_seen - b_abts, 1);
        chk("s5_err0", m_err[0] - b_err[0], 1);
        chk("s5_done0", m_done[0] - b_done[0], 0);

        // Tx_Done never returned: forced abort on timeout
        m_dly = -1;
        snap();
        Req_Valid = 4'b0010;
        wait_ng(b_ng + 1);
        Req_Valid = 4'b0000;
        wait_end(b_end + 1);
        chk("s5t_start", m_nstart - b_start, 1);
        chk("s5t_abort", m_nabort - b_abort, 1);
        chk("s5t_delay", m_t_abort - m_t_start, TMO + 2);
        chk("s5t_err1", m_err[1] - b_err[1], 1);
        chk("s5t_done1", m_done[1] - b_done[1], 0);

        // reset while waiting on Tx_Done
        m_dly = 50;
        snap();
        Req_Valid = 4'b0100;
        wait_ng(b_ng + 1);
        Req_Valid = 4'b0000;
        t = 0;
        while (m_nstart < b_start + 1 && t < 500) begin
            @(negedge Clk);
            t++;
        end
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        chk_quiet("s6");
        Rst = 1'b0;
        repeat (4) @(negedge Clk);
        chk("s6_done2", m_done[2] - b_done[2], 0);
        chk("s6_err2", m_err[2] - b_err[2], 0);
        chk("s6_nbuf", m_nbuf - b_nbuf, 1);

        chk("bus_wr_rd_overlap", m_both, 0);
        chk("grant_multi_hot", m_multi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
